// File: rtl/hazard_forward_unit.sv
// RAW hazard tracker: tags rd through EX/MEM/WB for ID/EX forwarding and load-use stall.
// Define HAZARD_STALL_CNT_EN to build the 32-bit load-use stall counter.
module hazard_forward_unit #(
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_reg_write,
    input  logic              id_is_load,
    input  logic              flush,
    output logic              mux_Sel_RAW_ID_rs1,
    output logic              mux_Sel_RAW_ID_rs2,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              stall_id,
    output logic [31:0]       stall_count
);

    logic              ex_v_q, ex_v_d;
    logic [REG_AW-1:0] ex_rd_q, ex_rd_d;
    logic              ex_ld_q, ex_ld_d;
    logic [REG_AW-1:0] ex_rs1_q, ex_rs1_d;
    logic [REG_AW-1:0] ex_rs2_q, ex_rs2_d;
    logic              mem_v_q;
    logic [REG_AW-1:0] mem_rd_q;
    logic              mem_ld_q;
    logic              wb_v_q;
    logic [REG_AW-1:0] wb_rd_q;

    logic ex_prod;
    logic mem_prod;
    logic wb_prod;
    logic mem_a, mem_b;
    logic wb_a, wb_b;

    assign ex_prod  = ex_v_q  && (ex_rd_q  != '0);
    assign mem_prod = mem_v_q && (mem_rd_q != '0);
    assign wb_prod  = wb_v_q  && (wb_rd_q  != '0);

    assign stall_id = id_valid && !flush && ex_prod && ex_ld_q &&
                      ((ex_rd_q == id_rs1) || (ex_rd_q == id_rs2));

    assign mux_Sel_RAW_ID_rs1 = wb_prod && (wb_rd_q == id_rs1);
    assign mux_Sel_RAW_ID_rs2 = wb_prod && (wb_rd_q == id_rs2);

    // A load in MEM has no result yet, so it never feeds the EX/MEM path
    assign mem_a = mem_prod && !mem_ld_q && (mem_rd_q == ex_rs1_q);
    assign mem_b = mem_prod && !mem_ld_q && (mem_rd_q == ex_rs2_q);
    assign wb_a  = wb_prod && (wb_rd_q == ex_rs1_q);
    assign wb_b  = wb_prod && (wb_rd_q == ex_rs2_q);

    always_comb begin
        fwd_a = 2'b00;
        unique case (1'b1)
            mem_a:          fwd_a = 2'b10;
            (!mem_a && wb_a): fwd_a = 2'b01;
            default:        fwd_a = 2'b00;
        endcase
    end

    always_comb begin
        fwd_b = 2'b00;
        unique case (1'b1)
            mem_b:          fwd_b = 2'b10;
            (!mem_b && wb_b): fwd_b = 2'b01;
            default:        fwd_b = 2'b00;
        endcase
    end

    always_comb begin
        ex_v_d   = 1'b0;
        ex_rd_d  = ex_rd_q;
        ex_ld_d  = ex_ld_q;
        ex_rs1_d = ex_rs1_q;
        ex_rs2_d = ex_rs2_q;
        if (!(flush || stall_id)) begin
            ex_v_d   = id_valid && id_reg_write;
            ex_rd_d  = id_rd;
            ex_ld_d  = id_is_load;
            ex_rs1_d = id_rs1;
            ex_rs2_d = id_rs2;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_v_q   <= 1'b0;
            ex_rd_q  <= '0;
            ex_ld_q  <= 1'b0;
            ex_rs1_q <= '0;
            ex_rs2_q <= '0;
            mem_v_q  <= 1'b0;
            mem_rd_q <= '0;
            mem_ld_q <= 1'b0;
            wb_v_q   <= 1'b0;
            wb_rd_q  <= '0;
        end else begin
            ex_v_q   <= ex_v_d;
            ex_rd_q  <= ex_rd_d;
            ex_ld_q  <= ex_ld_d;
            ex_rs1_q <= ex_rs1_d;
            ex_rs2_q <= ex_rs2_d;
            mem_v_q  <= ex_v_q;
            mem_rd_q <= ex_rd_q;
            mem_ld_q <= ex_ld_q;
            wb_v_q   <= mem_v_q;
            wb_rd_q  <= mem_rd_q;
        end
    end

`ifdef HAZARD_STALL_CNT_EN
    logic [31:0] cnt_q, cnt_d;

    assign cnt_d = stall_id ? cnt_q + 32'd1 : cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 32'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign stall_count = cnt_q;
`else
    assign stall_count = 32'h0;
`endif

endmodule
